xor4_stream_decoder: RTL and testbench
======================================

Name: xor4_stream_decoder

Overview:
- Decode side of the team's 4-bit XOR datapath. Takes a stream of 4-bit ciphertext nibbles and XORs each with a keystream nibble from an internal 4-bit LFSR to recover plaintext.
- Each plaintext nibble is presented with the same Z/N/C/V flag set the XOR ALU op produces.
- Valid/ready on both sides; one registered output stage. Sits between a nibble source (UART/switch bank) and the display/ALU consumer.

Parameters:
- SEED, 4'b1001, keystream register value after reset. Must be nonzero.
- CNT_W, 8, width of the decoded-nibble counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- load_seed  input  1  one-cycle strobe to reload keystream and flush
- seed_in  input  4  seed value used with load_seed
- in_valid  input  1  ciphertext nibble valid
- in_ready  output  1  decoder can accept in_data this cycle
- in_data  input  4  ciphertext nibble
- out_valid  output  1  plaintext nibble and flags valid
- out_ready  input  1  consumer accepts output this cycle
- out_data  output  4  plaintext nibble
- out_zero  output  1  out_data == 4'b0000
- out_negative  output  1  out_data[3]
- out_carry  output  1  constant 0 (logical op)
- out_overflow  output  1  constant 0 (logical op)
- nib_count  output  CNT_W  number of nibbles accepted since reset or seed load

Behaviour:
- Reset: single clock, synchronous, active-low; rst_n sampled low on a rising edge forces the following.
  - key = SEED, state = EMPTY, out_valid = 0.
  - out_data = 0, out_zero = 1, out_negative = 0, out_carry = 0, out_overflow = 0, nib_count = 0.
  - Reset overrides every other input, including mid-transfer.
- LFSR: Fibonacci, polynomial x^4+x^3+1.
  - key_next = {key[2:0], key[3]^key[2]}; period 15; never reaches 0.
  - From 1001 the sequence is 1001 -> 0011 -> 0110 -> 1101 -> 1010 -> ...
- FSM states:
  - EMPTY: output register holds no valid data.
  - FULL: output register holds data awaiting out_ready.
- in_ready = !load_seed && (state == EMPTY || out_ready). This is combinational; no dependency on in_valid.
- Accept: occurs when in_valid && in_ready at a clock edge.
  - out_data <= in_data ^ key; flags are computed from the new out_data.
  - key <= key_next.
  - nib_count <= nib_count + 1, wrapping modulo 2^CNT_W.
  - State goes to FULL.
- Latency: 1 cycle from accept to out_valid. Full throughput of one nibble per cycle while out_ready = 1.
- Transitions:
  - EMPTY & accept -> FULL.
  - FULL & out_ready & accept -> FULL, with new data loaded in the same cycle.
  - FULL & out_ready & !accept -> EMPTY.
  - FULL & !out_ready -> FULL; out_data and flags are held stable and in_ready = 0.
- out_valid = (state == FULL). Once asserted, out_data and flags do not change until the handshake completes.
- Flags are registered together with out_data; out_carry and out_overflow are always 0.
- load_seed (when rst_n high) has priority over accept and output handshake.
  - key <= (seed_in == 0) ? SEED : seed_in. Zero seed is replaced to avoid LFSR lockup.
  - State goes to EMPTY (pending output is discarded, even if out_ready = 1 that cycle).
  - nib_count <= 0; out_data and flags are cleared to their reset values.
  - in_ready = 0 in the load_seed cycle, so no nibble is consumed.
- In EMPTY, out_data and flags hold their last values but are don't-care to the consumer.
- No combinational path from in_data to out_data.

Test Plan:
- Reset then stream: rst_n low 2 cycles, out_ready = 1, send in_data 1001, 0011, 1110 on consecutive cycles -> out_data 0000 (zero = 1), 0000 (zero = 1), 1000 (negative = 1) one cycle after each accept; nib_count = 3; carry = overflow = 0 throughout.
- Backpressure: after one accept hold out_ready = 0 for 4 cycles while in_valid = 1 -> in_ready = 0, out_data stable, key not advanced; out_ready = 1 -> next nibble is accepted in that same cycle and out_valid stays 1.
- Seed reload: load_seed with seed_in = 0101 while FULL and out_ready = 1 -> out_valid = 0 next cycle, nib_count = 0, in_ready = 0 during the strobe; then in_data 0101 -> out_data 0000, zero = 1.
- Zero seed: load_seed with seed_in = 0000, then in_data 1001 -> out_data 0000, showing SEED was substituted.
- Keystream period: 15 accepts of in_data 0000 return the key sequence; the 16th output equals the 1st (1001, negative = 1).
- Reset mid-operation: rst_n low while FULL with out_ready = 0 -> next cycle out_valid = 0, nib_count = 0, key = SEED; subsequent in_data 1001 -> out_data 0000.

Source files
------------

// File: rtl/xor4_stream_decoder.sv
// Stream decoder: XORs each ciphertext nibble with a 4-bit LFSR keystream and
// presents the plaintext with XOR-op ALU flags through one registered valid/ready stage.
module xor4_stream_decoder #(
  parameter logic [3:0]  SEED  = 4'b1001,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic [3:0]       seed_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [CNT_W-1:0] nib_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] key;
  logic [3:0] key_step;
  logic [3:0] plain;
  logic       accept;

  // Fibonacci LFSR, x^4 + x^3 + 1: period 15, never reaches zero from a nonzero seed.
  assign key_step = {key[2:0], key[3] ^ key[2]};

  // A seed load blocks intake so the flushed cycle never consumes a nibble.
  assign in_ready  = !load_seed && (state == EMPTY || out_ready);
  assign accept    = in_valid && in_ready;
  assign plain     = in_data ^ key;
  assign out_valid = (state == FULL);

  // XOR is a logical op: carry and overflow are never set.
  assign out_carry    = 1'b0;
  assign out_overflow = 1'b0;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (load_seed) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_next = FULL;
        FULL:  if (out_ready && !accept) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key          <= SEED;
      out_data     <= 4'b0000;
      out_zero     <= 1'b1;
      out_negative <= 1'b0;
      nib_count    <= '0;
    end else if (load_seed) begin
      // A zero seed would lock the LFSR, so fall back to the default seed.
      key          <= (seed_in == 4'b0000) ? SEED : seed_in;
      out_data     <= 4'b0000;
      out_zero     <= 1'b1;
      out_negative <= 1'b0;
      nib_count    <= '0;
    end else if (accept) begin
      key          <= key_step;
      out_data     <= plain;
      out_zero     <= (plain == 4'b0000);
      out_negative <= plain[3];
      nib_count    <= nib_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xor4_stream_decoder.sv
// Directed bench for xor4_stream_decoder: hand-computed plaintext, flags and counts
// for reset, streaming, backpressure, seed reload, zero seed, keystream period and mid-run reset.
module tb_xor4_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       load_seed;
  logic [3:0] seed_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_zero;
  logic       out_negative;
  logic       out_carry;
  logic       out_overflow;
  logic [7:0] nib_count;

  int checks = 0;
  int errors = 0;

  // Keystream from 1001 under x^4 + x^3 + 1, computed by hand.
  logic [3:0] keys [15] = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                            4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                            4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

  xor4_stream_decoder #(.SEED(4'b1001), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_seed    (load_seed),
    .seed_in      (seed_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_zero     (out_zero),
    .out_negative (out_negative),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .nib_count    (nib_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_data, input logic [7:0] exp_cnt);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".zero"}, out_zero, exp_data == 4'b0000);
    check({tag, ".neg"}, out_negative, exp_data[3]);
    check({tag, ".carry"}, out_carry, 1'b0);
    check({tag, ".ovf"}, out_overflow, 1'b0);
    check({tag, ".cnt"}, nib_count, exp_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    load_seed = 1'b0;
    seed_in   = 4'b0000;
    in_valid  = 1'b0;
    in_data   = 4'b0000;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst.valid", out_valid, 1'b0);
    check("rst.data", out_data, 4'b0000);
    check("rst.zero", out_zero, 1'b1);
    check("rst.neg", out_negative, 1'b0);
    check("rst.cnt", nib_count, 8'd0);
    check("rst.in_ready", in_ready, 1'b1);

    // Stream three nibbles back to back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b1001;
    step();
    check_out("s0", 4'b0000, 8'd1);
    in_data = 4'b0011;
    step();
    check_out("s1", 4'b0000, 8'd2);
    in_data = 4'b1110;
    step();
    check_out("s2", 4'b1000, 8'd3);

    // Drain to EMPTY, then one accept with key 1101
    in_valid = 1'b0;
    step();
    check("drain.valid", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b0000;
    step();
    check_out("bp.load", 4'b1101, 8'd4);

    // Backpressure: output held, intake stalled, key frozen
    out_ready = 1'b0;
    #1;
    check("bp.in_ready", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("bp.hold", 4'b1101, 8'd4);
      check("bp.hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", in_ready, 1'b1);
    step();
    check_out("bp.release", 4'b1010, 8'd5);

    // Seed reload while FULL with out_ready high
    load_seed = 1'b1;
    seed_in   = 4'b0101;
    #1;
    check("seed.in_ready", in_ready, 1'b0);
    step();
    load_seed = 1'b0;
    check("seed.valid", out_valid, 1'b0);
    check("seed.cnt", nib_count, 8'd0);
    check("seed.data", out_data, 4'b0000);
    check("seed.zero", out_zero, 1'b1);
    in_data = 4'b0101;
    step();
    check_out("seed.first", 4'b0000, 8'd1);

    // Zero seed falls back to 1001
    in_valid  = 1'b0;
    load_seed = 1'b1;
    seed_in   = 4'b0000;
    step();
    load_seed = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b1001;
    step();
    check_out("zseed", 4'b0000, 8'd1);

    // Keystream period: restart from 1001 and decode 16 zero nibbles
    in_valid  = 1'b0;
    load_seed = 1'b1;
    seed_in   = 4'b1001;
    step();
    load_seed = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      step();
      check_out($sformatf("per%0d", i), keys[i % 15], 8'(i + 1));
    end

    // Reset while FULL and stalled
    out_ready = 1'b0;
    step();
    check("mid.full", out_valid, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("mid.valid", out_valid, 1'b0);
    check("mid.cnt", nib_count, 8'd0);
    check("mid.data", out_data, 4'b0000);
    check("mid.zero", out_zero, 1'b1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 4'b1001;
    step();
    check_out("mid.first", 4'b0000, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
